// File: rtl/aes_sbox_scheduler_if.sv
// ---------------------------------------------------------------------------
// aes_sbox_scheduler_if
// Bundles the three handshakes that meet at the shared S-box scheduler.
//   st_*   : cipher-state SubBytes request/response (128-bit state)
//   kw_*   : key-expansion SubWord request/response (32-bit word)
//   sbox_* : issue strobe/word to the S-box ROM and its registered result
// Modports:
//   master : the requesters plus the ROM (drive starts/data and sbox_out)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface aes_sbox_scheduler_if #(
    parameter int NWORDS = 4
);
    logic                     st_start;
    logic [32*NWORDS-1:0]     st_in;
    logic                     st_busy;
    logic                     st_done;
    logic [32*NWORDS-1:0]     st_result;

    logic                     kw_start;
    logic [31:0]              kw_in;
    logic [7:0]               kw_rcon;
    logic                     kw_busy;
    logic                     kw_done;
    logic [31:0]              kw_result;

    logic                     sbox_en;
    logic [31:0]              sbox_in;
    logic [31:0]              sbox_out;

    modport master (
        output st_start, st_in, kw_start, kw_in, kw_rcon, sbox_out,
        input  st_busy, st_done, st_result, kw_busy, kw_done, kw_result,
               sbox_en, sbox_in
    );

    modport slave (
        input  st_start, st_in, kw_start, kw_in, kw_rcon, sbox_out,
        output st_busy, st_done, st_result, kw_busy, kw_done, kw_result,
               sbox_en, sbox_in
    );
endinterface

// File: rtl/aes_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// aes_sbox_scheduler
// Time-multiplexes one 32-bit, 1-cycle registered S-box ROM between the
// cipher-state path (SubBytes over NWORDS words) and key expansion (SubWord).
// Ports:
//   clk    : clock
//   reset  : synchronous, active-low reset
//   bus    : aes_sbox_scheduler_if.slave (st_*, kw_*, sbox_* signals)
// Optional build macro AES_SBOX_KEY_ROTWORD_EN: key path applies RotWord
// before the S-box and XORs kw_rcon into byte 0 of the result.
// ---------------------------------------------------------------------------
module aes_sbox_scheduler #(
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_sbox_scheduler_if.slave   bus
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CW = $clog2(NWORDS + 1);

    logic [NWORDS-1:0][31:0] r_st_in;
    logic [NWORDS-1:0][31:0] r_st_part;
    logic [NWORDS-1:0][31:0] r_st_result;
    logic [CW-1:0]           r_st_idx;
    logic                    r_st_busy;
    logic                    r_st_done;

    logic [31:0]             r_kw_in;
    logic [31:0]             r_kw_result;
    logic                    r_kw_busy;
    logic                    r_kw_issued;
    logic                    r_kw_done;
`ifdef AES_SBOX_KEY_ROTWORD_EN
    logic [7:0]              r_kw_rcon;
`endif

    // One-deep in-flight tag: the ROM latency is fixed at one cycle.
    logic                    r_tag_vld;
    logic                    r_tag_key;
    logic [IW-1:0]           r_tag_idx;

    logic                    w_kw_elig;
    logic                    w_st_elig;
    logic                    w_iss_kw;
    logic                    w_iss_st;
    logic [IW-1:0]           w_st_sel;
    logic [31:0]             w_kw_word;
    logic [31:0]             w_kw_res;
    logic [31:0]             w_sbox_in;
    logic [NWORDS-1:0][31:0] w_st_final;

`ifdef AES_SBOX_KEY_ROTWORD_EN
    assign w_kw_word = {r_kw_in[7:0], r_kw_in[31:8]};
    assign w_kw_res  = bus.sbox_out ^ {24'h0, r_kw_rcon};
`else
    assign w_kw_word = r_kw_in;
    assign w_kw_res  = bus.sbox_out;
`endif

    // Key has priority; it holds at most one word, so state cannot starve.
    assign w_kw_elig = r_kw_busy && !r_kw_issued;
    assign w_st_elig = r_st_busy && (r_st_idx < CW'(NWORDS));
    assign w_iss_kw  = w_kw_elig;
    assign w_iss_st  = w_st_elig && !w_kw_elig;
    assign w_st_sel  = r_st_idx[IW-1:0];

    always_comb begin
        w_sbox_in = '0;
        if (w_iss_kw)
            w_sbox_in = w_kw_word;
        else if (w_iss_st)
            w_sbox_in = r_st_in[w_st_sel];
        // Final state word merges straight into the result register.
        w_st_final = r_st_part;
        w_st_final[r_tag_idx] = bus.sbox_out;
    end

    assign bus.sbox_en   = w_iss_kw | w_iss_st;
    assign bus.sbox_in   = w_sbox_in;
    assign bus.st_busy   = r_st_busy;
    assign bus.st_done   = r_st_done;
    assign bus.st_result = r_st_result;
    assign bus.kw_busy   = r_kw_busy;
    assign bus.kw_done   = r_kw_done;
    assign bus.kw_result = r_kw_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_st_in     <= '0;
            r_st_part   <= '0;
            r_st_result <= '0;
            r_st_idx    <= '0;
            r_st_busy   <= 1'b0;
            r_st_done   <= 1'b0;
            r_kw_in     <= '0;
            r_kw_result <= '0;
            r_kw_busy   <= 1'b0;
            r_kw_issued <= 1'b0;
            r_kw_done   <= 1'b0;
`ifdef AES_SBOX_KEY_ROTWORD_EN
            r_kw_rcon   <= '0;
`endif
            r_tag_vld   <= 1'b0;
            r_tag_key   <= 1'b0;
            r_tag_idx   <= '0;
        end else begin
            r_kw_done <= 1'b0;
            r_st_done <= 1'b0;

            // Collect: busy drops together with the done pulse.
            if (r_tag_vld) begin
                if (r_tag_key) begin
                    r_kw_result <= w_kw_res;
                    r_kw_done   <= 1'b1;
                    r_kw_busy   <= 1'b0;
                    r_kw_issued <= 1'b0;
                end else begin
                    r_st_part[r_tag_idx] <= bus.sbox_out;
                    if (r_tag_idx == IW'(NWORDS - 1)) begin
                        r_st_result <= w_st_final;
                        r_st_done   <= 1'b1;
                        r_st_busy   <= 1'b0;
                    end
                end
            end

            // Capture: only an idle channel accepts a start.
            if (bus.st_start && !r_st_busy) begin
                r_st_in   <= bus.st_in;
                r_st_busy <= 1'b1;
                r_st_idx  <= '0;
            end
            if (bus.kw_start && !r_kw_busy) begin
                r_kw_in   <= bus.kw_in;
`ifdef AES_SBOX_KEY_ROTWORD_EN
                r_kw_rcon <= bus.kw_rcon;
`endif
                r_kw_busy <= 1'b1;
            end

            // Issue bookkeeping.
            r_tag_vld <= w_iss_kw | w_iss_st;
            r_tag_key <= w_iss_kw;
            r_tag_idx <= w_st_sel;
            if (w_iss_kw)
                r_kw_issued <= 1'b1;
            if (w_iss_st)
                r_st_idx <= r_st_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_sbox_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aes_sbox_scheduler
// Random and directed stimulus against a timestamp-based schedule model.
// Expected results come from a S-box computed from GF(2^8) inversion plus
// the AES affine map; a few literal vectors pin that model.
// ---------------------------------------------------------------------------
module tb_aes_sbox_scheduler;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_sbox_scheduler_if #(.NWORDS(NW)) bus();
    aes_sbox_scheduler #(.NWORDS(NW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] sb [256];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // ---------------- reference S-box ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] subbytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
        return r;
    endfunction

    // ROM: registered, one cycle latency.
    always @(posedge clk) bus.sbox_out <= subw(bus.sbox_in);

    // ---------------- behavioural schedule model ----------------
    bit           m_valid = 0;
    bit           m_kw_busy, m_kw_uniss, m_st_busy;
    int           m_kw_done_at = -1, m_st_done_at = -1, m_st_next;
    logic [31:0]  m_kw_word, m_kw_exp, m_kw_res;
    logic [127:0] m_st_in, m_st_exp, m_st_res;

    int          obs_st_done = -1, obs_kw_done = -1;
    logic [32:0] log_io [int];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        m_kw_busy = 0; m_kw_uniss = 0; m_st_busy = 0; m_st_next = 0;
        m_kw_done_at = -1; m_st_done_at = -1;
        m_kw_res = '0; m_st_res = '0;
        m_valid = 1;
    endtask

    task automatic model_check();
        logic e_kwd, e_std, e_en;
        logic [31:0] e_in;
        if (!m_valid) return;
        e_kwd = (cyc == m_kw_done_at);
        if (e_kwd) begin m_kw_busy = 0; m_kw_res = m_kw_exp; m_kw_done_at = -1; end
        e_std = (cyc == m_st_done_at);
        if (e_std) begin m_st_busy = 0; m_st_res = m_st_exp; m_st_done_at = -1; end
        chk("kw_busy",   bus.kw_busy,   m_kw_busy);
        chk("kw_done",   bus.kw_done,   e_kwd);
        chk("kw_result", bus.kw_result, m_kw_res);
        chk("st_busy",   bus.st_busy,   m_st_busy);
        chk("st_done",   bus.st_done,   e_std);
        chk("st_result", bus.st_result, m_st_res);
        e_en = 0; e_in = '0;
        if (m_kw_busy && m_kw_uniss) begin
            e_en = 1; e_in = m_kw_word; m_kw_uniss = 0; m_kw_done_at = cyc + 2;
        end else if (m_st_busy && m_st_next < NW) begin
            e_en = 1; e_in = m_st_in[32*m_st_next +: 32];
            if (m_st_next == NW - 1) m_st_done_at = cyc + 2;
            m_st_next++;
        end
        chk("sbox_en", bus.sbox_en, e_en);
        chk("sbox_in", bus.sbox_in, e_in);
    endtask

    task automatic model_capture(input bit sts, input logic [127:0] stv, input bit kws,
                                 input logic [31:0] kwv, input logic [7:0] rc, input bit rst);
        if (rst) begin model_reset(); return; end
        if (!m_valid) return;
        if (sts && !m_st_busy) begin
            m_st_busy = 1; m_st_next = 0; m_st_in = stv; m_st_exp = subbytes(stv);
        end
        if (kws && !m_kw_busy) begin
            m_kw_busy = 1; m_kw_uniss = 1;
`ifdef AES_SBOX_KEY_ROTWORD_EN
            m_kw_word = {kwv[7:0], kwv[31:8]};
            m_kw_exp  = subw(m_kw_word) ^ {24'h0, rc};
`else
            m_kw_word = kwv;
            m_kw_exp  = subw(kwv);
`endif
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then drive this cycle's inputs.
    task automatic step(input bit sts, input logic [127:0] stv, input bit kws,
                        input logic [31:0] kwv, input logic [7:0] rc, input bit rst);
        @(negedge clk);
        log_io[cyc] = {bus.sbox_en, bus.sbox_in};
        if (bus.st_done === 1'b1) obs_st_done = cyc;
        if (bus.kw_done === 1'b1) obs_kw_done = cyc;
        model_check();
        bus.st_start = sts; bus.st_in = stv;
        bus.kw_start = kws; bus.kw_in = kwv; bus.kw_rcon = rc;
        reset = rst ? 1'b0 : 1'b1;
        model_capture(sts, stv, kws, kwv, rc, rst);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, 0, '0, '0, 0);
    endtask

    localparam logic [127:0] ST0  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ST0R = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
`ifdef AES_SBOX_KEY_ROTWORD_EN
    localparam logic [31:0] K0R   = 32'h63636362;
    localparam logic [31:0] K1ISS = 32'h04010203;
`else
    localparam logic [31:0] K0R   = 32'h63636363;
    localparam logic [31:0] K1ISS = 32'h01020304;
`endif

    initial begin
        int s, en_cnt;
        logic [31:0] wl [4];
        wl[0] = 32'hccddeeff; wl[1] = 32'h8899aabb; wl[2] = 32'h44556677; wl[3] = 32'h00112233;
        build_sbox();
        bus.st_start = 0; bus.st_in = '0; bus.kw_start = 0; bus.kw_in = '0; bus.kw_rcon = '0;
        chk("sbox_00", sb[8'h00], 8'h63);
        chk("sbox_53", sb[8'h53], 8'hed);

        repeat (3) step(0, '0, 0, '0, '0, 1);

        // idle after reset
        s = cyc; idle(5); en_cnt = 0;
        for (int c = s; c < s + 5; c++) en_cnt += int'(log_io[c][32]);
        chk("idle_en", en_cnt, 0);

        // key alone
        s = cyc; obs_kw_done = -1;
        step(0, '0, 1, 32'h0, 8'h01, 0); idle(4);
        chk("kw_lat", obs_kw_done - s, 3);
        chk("kw_res0", bus.kw_result, K0R);

        // state alone
        s = cyc; obs_st_done = -1;
        step(1, ST0, 0, '0, '0, 0); idle(7);
        for (int i = 0; i < 4; i++) chk("st_issue", log_io[s + 1 + i], {1'b1, wl[i]});
        chk("st_lat", obs_st_done - s, 6);
        chk("st_res0", bus.st_result, ST0R);

        // simultaneous starts, second state start ignored while busy
        s = cyc; obs_st_done = -1; obs_kw_done = -1;
        step(1, ST0, 1, 32'h0, 8'h01, 0); idle(2);
        step(1, {4{32'hdeadbeef}}, 0, '0, '0, 0); idle(6);
        chk("sim_kiss", log_io[s + 1], {1'b1, 32'h0});
        chk("sim_kw_lat", obs_kw_done - s, 3);
        chk("sim_st_lat", obs_st_done - s, 7);
        chk("sim_st_res", bus.st_result, ST0R);

        // key steals one slot mid-burst
        s = cyc; obs_st_done = -1;
        step(1, ST0, 0, '0, '0, 0);
        step(0, '0, 1, 32'h01020304, 8'h36, 0); idle(8);
        chk("steal_kiss", log_io[s + 2], {1'b1, K1ISS});
        chk("steal_w1", log_io[s + 3], {1'b1, wl[1]});
        chk("steal_lat", obs_st_done - s, 7);

        // reset mid-request, then a fresh request
        s = cyc; obs_st_done = -1;
        step(1, ST0, 0, '0, '0, 0); idle(2);
        step(0, '0, 0, '0, '0, 1); idle(5);
        chk("rst_nodone", obs_st_done, -1);
        s = cyc;
        step(1, ST0, 0, '0, '0, 0); idle(7);
        chk("post_rst_lat", obs_st_done - s, 6);
        chk("post_rst_res", bus.st_result, ST0R);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) == 0, {$urandom, $urandom, $urandom, $urandom},
                 ($urandom % 3) == 0, $urandom, 8'($urandom), ($urandom % 80) == 0);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
